// File: rtl/common_pkg.sv
// Shared BFT switch definitions: port indices and address-routing helpers.
package common_pkg;

    localparam int PORT_L   = 0;
    localparam int PORT_R   = 1;
    localparam int PORT_U0  = 2;
    localparam int PORT_U1  = 3;
    localparam int FLIT_MAX = 512;

    typedef logic [1:0] port_t;

    function automatic logic [31:0] addr_field(
        logic [FLIT_MAX-1:0] flit,
        int dw,
        int aw
    );
        logic [FLIT_MAX-1:0] s;
        logic [31:0] m;
        s = flit >> (dw - aw);
        m = (32'd1 << aw) - 32'd1;
        return s[31:0] & m;
    endfunction

    function automatic logic is_local(
        logic [31:0] a,
        int posl,
        int posx
    );
        return (a >> (posl + 1)) == 32'(posx);
    endfunction

    function automatic port_t down_port(
        logic [31:0] a,
        int posl
    );
        return a[posl] ? port_t'(PORT_R) : port_t'(PORT_L);
    endfunction

endpackage

// File: rtl/bp_pi_switch_if.sv
// Valid/ready flit bundle for all ports of a BFT switch.
interface bp_pi_switch_if #(
    parameter int P   = 4,
    parameter int D_W = 32
);
    logic [P-1:0]          in_valid;
    logic [P-1:0]          in_ready;
    logic [P-1:0][D_W-1:0] in_data;
    logic [P-1:0]          out_valid;
    logic [P-1:0]          out_ready;
    logic [P-1:0][D_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bp_pi_switch_arb.sv
// Round-robin arbiter: one-hot grant, search starts at last grant + 1.
module bp_rr_arbiter #(
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [P-1:0] req,
    output logic [P-1:0] gnt
);
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;
    logic          found;

    always_comb begin
        gnt   = '0;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < P; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= P) idx = idx - P;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                sel      = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (sel == PW'(P - 1)) ? '0 : sel + 1'b1;
        end
    end

endmodule

// File: rtl/bp_pi_switch.sv
// Backpressure BFT switch: per-input FIFOs, address routing, RR outputs.
// Define BP_PI_SWITCH_ASSERT_EN to compile simulation assertions.
module bp_pi_switch
    import common_pkg::*;
#(
    parameter int N           = 8,
    parameter int A_W         = $clog2(N) + 1,
    parameter int D_W         = 32,
    parameter int posl        = 0,
    parameter int posx        = 0,
    parameter int NUM_UP      = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int GENERALIZED = 0
) (
    input logic           clk,
    input logic           rst,
    bp_pi_switch_if.slave bus
);
    localparam int P  = 2 + NUM_UP;
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;

    logic [D_W-1:0] mem  [P][FIFO_DEPTH];
    logic [FW-1:0]  wp   [P];
    logic [FW-1:0]  rp   [P];
    logic [CW-1:0]  cnt  [P];
    logic [CW-1:0]  cnxt [P];
    logic [D_W-1:0] head [P];
    logic [31:0]    a    [P];
    port_t          tgt  [P];
    logic [P-1:0]   req  [P];
    logic [P-1:0]   gnt  [P];
    logic [D_W-1:0] odat [P];

    logic [P-1:0] rdy_q;
    logic [P-1:0] push;
    logic [P-1:0] pop;
    logic [P-1:0] hv;
    logic [P-1:0] tog;
    logic [P-1:0] free;
    logic [P-1:0] ov;

    logic [P-1:0][D_W-1:0] od;

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = ov;
    assign bus.out_data  = od;
    assign push          = bus.in_valid & rdy_q;
    assign free          = ~ov | bus.out_ready;

    always_comb begin
        for (int i = 0; i < P; i++) begin
            hv[i]   = (cnt[i] != '0);
            head[i] = mem[i][rp[i]];
            cnxt[i] = cnt[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    // Only l/r inputs may turn upward; parent inputs always descend.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            a[i]   = addr_field(FLIT_MAX'(head[i]), D_W, A_W);
            tgt[i] = down_port(a[i], posl);
            if (i < 2 && !is_local(a[i], posl, posx)) begin
                if (NUM_UP == 1)
                    tgt[i] = port_t'(PORT_U0);
                else if (GENERALIZED != 0)
                    tgt[i] = a[i][posl+1] ? port_t'(PORT_U1)
                                          : port_t'(PORT_U0);
                else
                    tgt[i] = tog[i] ? port_t'(PORT_U1)
                                    : port_t'(PORT_U0);
            end
        end
    end

    always_comb begin
        for (int o = 0; o < P; o++) begin
            for (int i = 0; i < P; i++) begin
                req[o][i] = hv[i] && (tgt[i] == port_t'(o));
            end
        end
    end

    for (genvar o = 0; o < P; o++) begin : g_arb
        bp_rr_arbiter #(
            .P (P)
        ) u_arb (
            .clk (clk),
            .rst (rst),
            .en  (free[o]),
            .req (req[o]),
            .gnt (gnt[o])
        );
    end

    always_comb begin
        pop = '0;
        for (int o = 0; o < P; o++) begin
            odat[o] = '0;
            for (int i = 0; i < P; i++) begin
                pop[i] = pop[i] | gnt[o][i];
                if (gnt[o][i]) odat[o] = head[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < P; i++) begin
            if (push[i]) mem[i][wp[i]] <= bus.in_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q <= '0;
            tog   <= '0;
            for (int i = 0; i < P; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < P; i++) begin
                if (push[i]) wp[i] <= wp[i] + 1'b1;
                if (pop[i])  rp[i] <= rp[i] + 1'b1;
                cnt[i]   <= cnxt[i];
                rdy_q[i] <= (cnxt[i] != CW'(FIFO_DEPTH));
                if (GENERALIZED == 0 && NUM_UP == 2 && pop[i] &&
                    tgt[i] >= port_t'(PORT_U0))
                    tog[i] <= ~tog[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ov <= '0;
            od <= '0;
        end else begin
            for (int o = 0; o < P; o++) begin
                if (free[o]) begin
                    ov[o] <= |gnt[o];
                    if (|gnt[o]) od[o] <= odat[o];
                end
            end
        end
    end

`ifdef BP_PI_SWITCH_ASSERT_EN
    logic [P-1:0] gcol [P];

    always_comb begin
        for (int i = 0; i < P; i++) begin
            gcol[i] = '0;
            for (int o = 0; o < P; o++) gcol[i][o] = gnt[o][i];
        end
    end

    for (genvar o = 0; o < P; o++) begin : g_sva
        a_stable: assert property (
            @(posedge clk) disable iff (!rst)
            (ov[o] && !bus.out_ready[o]) |=> $stable(od[o])
        );
    end

    always @(posedge clk) begin
        if (rst) begin
            a_up: assert (NUM_UP == 1 || NUM_UP == 2);
            a_pow2: assert (FIFO_DEPTH >= 2 &&
                (FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);
            for (int i = 0; i < P; i++) begin
                a_full: assert (!(push[i] &&
                    cnt[i] == CW'(FIFO_DEPTH)));
                a_one: assert ($onehot0(gcol[i]));
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_pi_switch.sv
// Directed bench for bp_pi_switch: default, NUM_UP=1, GENERALIZED=1.
module tb_bp_pi_switch;

    logic clk;
    logic rst;
    int   nchk;
    int   nerr;

    bp_pi_switch_if #(.P(4), .D_W(32)) ia ();
    bp_pi_switch_if #(.P(3), .D_W(32)) ib ();
    bp_pi_switch_if #(.P(4), .D_W(32)) ic ();

    bp_pi_switch u_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    bp_pi_switch #(.NUM_UP(1)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    bp_pi_switch #(.GENERALIZED(1)) u_c (
        .clk (clk),
        .rst (rst),
        .bus (ic)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cap  [4][32];
    int          ncap [4];
    int          base [4];

    initial begin
        for (int p = 0; p < 4; p++) ncap[p] = 0;
    end

    always @(negedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (ia.out_valid[p] && ia.out_ready[p]) begin
                if (ncap[p] < 32) cap[p][ncap[p]] = ia.out_data[p];
                ncap[p] = ncap[p] + 1;
            end
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int p = 0; p < 4; p++) base[p] = ncap[p];
    endtask

    function automatic logic [31:0] got(int p, int k);
        int j;
        j = base[p] + k;
        if (j >= 32) return 32'hdead_beef;
        return cap[p][j];
    endfunction

    task automatic send_a(int p, logic [31:0] d);
        logic ok;
        ok = 1'b0;
        ia.in_valid[p] = 1'b1;
        ia.in_data[p]  = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ia.in_ready[p]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        ia.in_valid[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nchk = 0;
        nerr = 0;
        rst  = 1'b0;
        ia.in_valid  = '0;
        ia.in_data   = '0;
        ia.out_ready = '1;
        ib.in_valid  = '0;
        ib.in_data   = '0;
        ib.out_ready = '1;
        ic.in_valid  = '0;
        ic.in_data   = '0;
        ic.out_ready = '1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(ia.out_valid), 32'h0);
        check("rst_in_ready", 32'(ia.in_ready), 32'h0);
        check("rst_out_data_r", ia.out_data[1], 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(ia.in_ready), 32'hf);

        // l -> r, one flit, minimum latency
        ia.in_valid[0] = 1'b1;
        ia.in_data[0]  = 32'h1000_00aa;
        @(posedge clk);
        #1;
        ia.in_valid[0] = 1'b0;
        check("lat_k", 32'(ia.out_valid), 32'h0);
        @(posedge clk);
        #1;
        check("lat_k1_valid", 32'(ia.out_valid), 32'h2);
        check("lat_k1_data", ia.out_data[1], 32'h1000_00aa);
        @(posedge clk);
        #1;
        check("lat_k2_valid", 32'(ia.out_valid), 32'h0);

        // l and r both send to addr 6: toggled up-port choice
        snap();
        for (int k = 1; k <= 3; k++) begin
            ia.in_valid[0] = 1'b1;
            ia.in_valid[1] = 1'b1;
            ia.in_data[0]  = 32'h6000_0000 + 32'(k);
            ia.in_data[1]  = 32'h6000_0010 + 32'(k);
            @(posedge clk);
            #1;
        end
        ia.in_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        check("up_u0_cnt", 32'(ncap[2] - base[2]), 32'd4);
        check("up_u1_cnt", 32'(ncap[3] - base[3]), 32'd2);
        check("up_u0_0", got(2, 0), 32'h6000_0001);
        check("up_u0_1", got(2, 1), 32'h6000_0011);
        check("up_u0_2", got(2, 2), 32'h6000_0003);
        check("up_u0_3", got(2, 3), 32'h6000_0013);
        check("up_u1_0", got(3, 0), 32'h6000_0002);
        check("up_u1_1", got(3, 1), 32'h6000_0012);

        // u0 and u1 contend for l
        snap();
        for (int k = 1; k <= 2; k++) begin
            ia.in_valid[2] = 1'b1;
            ia.in_valid[3] = 1'b1;
            ia.in_data[2]  = 32'h0000_0020 + 32'(k);
            ia.in_data[3]  = 32'h0000_0030 + 32'(k);
            @(posedge clk);
            #1;
        end
        ia.in_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        check("rr_cnt", 32'(ncap[0] - base[0]), 32'd4);
        check("rr_0", got(0, 0), 32'h0000_0021);
        check("rr_1", got(0, 1), 32'h0000_0031);
        check("rr_2", got(0, 2), 32'h0000_0022);
        check("rr_3", got(0, 3), 32'h0000_0032);

        // backpressure on r: fill FIFO behind held output
        snap();
        ia.out_ready[1] = 1'b0;
        for (int k = 1; k <= 5; k++) send_a(0, 32'h1000_0000 + 32'(k));
        check("bp_in_ready", 32'(ia.in_ready[0]), 32'h0);
        check("bp_out_valid", 32'(ia.out_valid[1]), 32'h1);
        check("bp_out_data", ia.out_data[1], 32'h1000_0001);
        ia.in_valid[0] = 1'b1;
        ia.in_data[0]  = 32'h1000_0006;
        @(posedge clk);
        #1;
        ia.in_valid[0] = 1'b0;
        check("bp_full_hold", 32'(ia.in_ready[0]), 32'h0);
        check("bp_data_stable", ia.out_data[1], 32'h1000_0001);
        ia.out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_rise", 32'(ia.in_ready[0]), 32'h1);
        repeat (6) @(posedge clk);
        #1;
        check("bp_cnt", 32'(ncap[1] - base[1]), 32'd5);
        for (int k = 0; k < 5; k++)
            check("bp_order", got(1, k), 32'h1000_0001 + 32'(k));

        // NUM_UP=1: up traffic always lands on u0
        for (int k = 1; k <= 2; k++) begin
            ib.in_valid[1] = 1'b1;
            ib.in_data[1]  = 32'h4000_0050 + 32'(k);
            @(posedge clk);
            #1;
            ib.in_valid[1] = 1'b0;
            @(posedge clk);
            #1;
            check("t_valid", 32'(ib.out_valid), 32'h4);
            check("t_data", ib.out_data[2], 32'h4000_0050 + 32'(k));
        end

        // GENERALIZED=1: up port picked by a[posl+1]
        ic.in_valid[0] = 1'b1;
        ic.in_data[0]  = 32'h2000_0061;
        @(posedge clk);
        #1;
        ic.in_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        check("gen_a2_valid", 32'(ic.out_valid), 32'h8);
        check("gen_a2_data", ic.out_data[3], 32'h2000_0061);
        ic.in_valid[0] = 1'b1;
        ic.in_data[0]  = 32'h4000_0062;
        @(posedge clk);
        #1;
        ic.in_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        check("gen_a4_valid", 32'(ic.out_valid), 32'h4);

        // reset in the middle of a buffered burst
        ia.out_ready[1] = 1'b0;
        for (int k = 1; k <= 3; k++) send_a(0, 32'h1000_0070 + 32'(k));
        check("mid_pre_valid", 32'(ia.out_valid[1]), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_out_valid", 32'(ia.out_valid), 32'h0);
        check("mid_in_ready", 32'(ia.in_ready), 32'h0);
        ia.out_ready = '1;
        snap();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_ready_back", 32'(ia.in_ready), 32'hf);
        repeat (5) @(posedge clk);
        #1;
        check("mid_no_stale",
            32'(ncap[0] + ncap[1] + ncap[2] + ncap[3] -
                base[0] - base[1] - base[2] - base[3]), 32'd0);
        check("mid_idle", 32'(ia.out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
